pcap_replay_multiq_sched: RTL and testbench
===========================================

// Module: pcap_replay_multiq_sched
// PURPOSE
//  - N-queue replay read scheduler for the pcap replay uEngine: per-queue QDR address window [low,high],
//    per-queue replay count, round-robin arbitration of burst read requests toward the QDR read port.
//  - Successor to the fixed 4-queue register decode: queue count, address width and step are parameters.
//  - Adds per-queue done/busy status, infinite-replay mode and downstream backpressure per queue.
// PARAMETERS
//  C_NUM_QUEUES        4    number of replay queues (1..16)
//  QDR_ADDR_WIDTH      19   QDR word address width
//  REPLAY_COUNT_WIDTH  32   replay iteration counter width
//  C_ADDR_STEP         1    address increment per accepted burst request
//  C_QID_WIDTH         2    width of rd_req_qid; must be >= clog2(C_NUM_QUEUES)
// PORTS
//  axi_aclk            in   1                          single clock
//  axi_aresetn         in   1                          async active-low reset
//  sw_rst              in   1                          sync soft reset, same effect as axi_aresetn
//  cfg_enable          in   C_NUM_QUEUES               per-queue enable (level)
//  cfg_addr_low        in   C_NUM_QUEUES*QDR_ADDR_WIDTH     queue i at [i*AW +: AW]
//  cfg_addr_high       in   C_NUM_QUEUES*QDR_ADDR_WIDTH     inclusive last address of queue i
//  cfg_replay_count    in   C_NUM_QUEUES*REPLAY_COUNT_WIDTH 0 = replay forever
//  q_ready             in   C_NUM_QUEUES               queue i's output FIFO can take one burst
//  rd_req_valid        out  1                          read request valid
//  rd_req_ready        in   1                          QDR read port accepts request
//  rd_req_addr         out  QDR_ADDR_WIDTH             burst start address
//  rd_req_qid          out  C_QID_WIDTH                owning queue
//  q_busy              out  C_NUM_QUEUES               queue in RUN
//  q_done              out  C_NUM_QUEUES               queue finished its replay count
//  q_cfg_err           out  C_NUM_QUEUES               high<low at start; sticky until enable low
// BEHAVIOUR
//  - Reset (either): all queues IDLE; rd_req_valid/addr/qid, q_busy, q_done, q_cfg_err = 0; rr pointer = 0.
//  - Per-queue FSM IDLE/RUN/DONE. IDLE->RUN on enable rising edge (sampled 0 then 1); ptr<=low, iter<=0.
//    If high<low on that edge: ->DONE with q_cfg_err=1, q_done=0; no requests issued.
//  - RUN: queue eligible when q_ready[i] and no request of its own held in output register.
//  - Arbiter: output register loads when empty or accepted this cycle (rd_req_valid&rd_req_ready);
//    picks first eligible queue at/after rr pointer; rr <= grant+1 mod N. Throughput 1 request/cycle.
//  - Latency: enable edge sampled cycle T -> RUN at T+1 -> rd_req_valid at T+2 (if q_ready, port free).
//  - Handshake: while rd_req_valid & !rd_req_ready, addr/qid held stable; q_ready drop does not retract.
//  - On accept of queue i: if ptr+C_ADDR_STEP > high (compare at QDR_ADDR_WIDTH+1 bits, no overflow):
//    ptr<=low, iter<=iter+1; if replay_count!=0 and iter+1==replay_count -> DONE; else ptr+=C_ADDR_STEP.
//  - Replay count 0: wrap forever; iter saturates at all-ones.
//  - Single-address window (low==high): each accept is one full iteration.
//  - Enable low in RUN: no new grants; a held request completes its handshake, then ->IDLE (no wrap effect).
//    Enable low with no held request: ->IDLE next cycle. Enable low in DONE: ->IDLE, q_done/q_cfg_err clear.
//  - Enable falling same cycle as accept: accept counts (ptr/iter update), then IDLE.
//  - cfg_addr/count sampled at start and on each wrap; changes mid-iteration take effect at wrap.
//  - q_busy=1 in RUN; q_done=1 in DONE (unless q_cfg_err).
//  - sw_rst mid-handshake: rd_req_valid drops next edge (the only permitted retraction).
// CONFIGURATION
//  - PCAP_REPLAY_SCHED_STATS_EN defined: adds out stat_req_count [C_NUM_QUEUES*32], per-queue count of
//    accepted requests, wrapping at 2^32, cleared by reset and on IDLE->RUN of that queue.
//  - Not defined: port and counters absent; all other behaviour identical.
// TESTING
//  - q0 en, low=0x10 high=0x13 count=2, ready=1 -> addrs 10,11,12,13,10,11,12,13 qid0; q_done[0] at +1 cycle.
//  - q0,q1,q2 en, count=0, all ready, rd_req_ready=1 -> qid 0,1,2,0,1,2 back-to-back, no idle cycles.
//  - rd_req_ready=0 for 5 cycles with valid high -> addr/qid unchanged; q_ready[qid] dropped meanwhile too.
//  - q1 low=0x20 high=0x1F en -> q_cfg_err[1]=1, no request qid1; enable low -> err clears.
//  - q0 count=0, disable during held request -> request accepted, q_busy[0]=0 next cycle, no more qid0.
//  - axi_aresetn low mid-run, then re-enable -> restart at low, iter=0 (stats=0 with STATS_EN).

Source files
------------

// File: rtl/pcap_replay_multiq_sched.sv
// rtl/pcap_replay_multiq_sched.sv - N-queue round-robin replay read scheduler for the QDR read port
//
// Purpose:
//   Each replay queue walks its QDR word-address window [low, high] one burst at a time.
//   It repeats the window replay_count times; a count of 0 means it repeats forever.
//   A round-robin arbiter merges the queues' burst requests into one registered
//   valid/ready read-request port.
//
// Ports:
//   axi_aclk, axi_aresetn  clock, asynchronous active-low reset
//   sw_rst                 synchronous soft reset, same effect as axi_aresetn
//   cfg_enable[i]          queue i enable level; a 0->1 edge starts a replay
//   cfg_addr_low/high      queue i window at [i*QDR_ADDR_WIDTH +: QDR_ADDR_WIDTH], inclusive
//   cfg_replay_count       queue i iteration count at [i*REPLAY_COUNT_WIDTH +: ...], 0 = forever
//   q_ready[i]             queue i output FIFO can take one more burst
//   rd_req_*               burst read request toward the QDR read port
//   q_busy/q_done/q_cfg_err  per-queue status: running, finished, window had high < low
//   stat_req_count         (PCAP_REPLAY_SCHED_STATS_EN only) per-queue count of accepted requests
//
// Optional feature macro: PCAP_REPLAY_SCHED_STATS_EN
module pcap_replay_multiq_sched #(
    parameter int C_NUM_QUEUES       = 4,
    parameter int QDR_ADDR_WIDTH     = 19,
    parameter int REPLAY_COUNT_WIDTH = 32,
    parameter int C_ADDR_STEP        = 1,
    parameter int C_QID_WIDTH        = 2
) (
    input  logic                                         axi_aclk,
    input  logic                                         axi_aresetn,
    input  logic                                         sw_rst,
    input  logic [C_NUM_QUEUES-1:0]                      cfg_enable,
    input  logic [C_NUM_QUEUES*QDR_ADDR_WIDTH-1:0]       cfg_addr_low,
    input  logic [C_NUM_QUEUES*QDR_ADDR_WIDTH-1:0]       cfg_addr_high,
    input  logic [C_NUM_QUEUES*REPLAY_COUNT_WIDTH-1:0]   cfg_replay_count,
    input  logic [C_NUM_QUEUES-1:0]                      q_ready,
    output logic                                         rd_req_valid,
    input  logic                                         rd_req_ready,
    output logic [QDR_ADDR_WIDTH-1:0]                    rd_req_addr,
    output logic [C_QID_WIDTH-1:0]                       rd_req_qid,
    output logic [C_NUM_QUEUES-1:0]                      q_busy,
    output logic [C_NUM_QUEUES-1:0]                      q_done,
    output logic [C_NUM_QUEUES-1:0]                      q_cfg_err
`ifdef PCAP_REPLAY_SCHED_STATS_EN
    ,
    output logic [C_NUM_QUEUES*32-1:0]                   stat_req_count
`endif
);

    localparam int N  = C_NUM_QUEUES;
    localparam int AW = QDR_ADDR_WIDTH;
    localparam int RW = REPLAY_COUNT_WIDTH;
    localparam int QW = C_QID_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Output request register and round-robin pointer
    logic          r_valid;
    logic [AW-1:0] r_addr;
    logic [QW-1:0] r_qid;
    logic [QW-1:0] r_rr;

    logic          w_accept;
    logic [N-1:0]  w_elig;
    logic [AW-1:0] w_addr_eff [N];

    logic          w_found;
    logic [QW-1:0] w_gnt_qid;
    logic [AW-1:0] w_gnt_addr;
    logic [QW-1:0] w_gnt_rr;

    assign w_accept     = r_valid & rd_req_ready;
    assign rd_req_valid = r_valid;
    assign rd_req_addr  = r_addr;
    assign rd_req_qid   = r_qid;

    for (genvar g = 0; g < N; g++) begin : g_q
        state_t        r_state;
        logic          r_en_d;
        logic          r_cfg_err;
        logic [AW-1:0] r_ptr;
        logic [AW-1:0] r_high;
        logic [RW-1:0] r_iter;
        logic [RW-1:0] r_count;

        logic [AW-1:0] w_low_cfg;
        logic [AW-1:0] w_high_cfg;
        logic [RW-1:0] w_count_cfg;
        logic [RW-1:0] w_iter_inc;
        logic [AW-1:0] w_next_ptr;
        logic          w_start;
        logic          w_acc;
        logic          w_held;
        logic          w_wrap;
        logic          w_fin;

        assign w_low_cfg   = cfg_addr_low[g*AW +: AW];
        assign w_high_cfg  = cfg_addr_high[g*AW +: AW];
        assign w_count_cfg = cfg_replay_count[g*RW +: RW];

        assign w_start = (r_state == S_IDLE) && cfg_enable[g] && !r_en_d;
        assign w_acc   = w_accept && (r_qid == QW'(g));
        // Own request still sitting in the output register after this cycle
        assign w_held  = r_valid && (r_qid == QW'(g)) && !w_accept;

        // One extra bit so a window ending at the top of the address space cannot overflow
        assign w_wrap     = ({1'b0, r_ptr} + (AW+1)'(C_ADDR_STEP)) > {1'b0, r_high};
        assign w_iter_inc = (&r_iter) ? r_iter : r_iter + RW'(1);
        assign w_fin      = w_wrap && (r_count != '0) &&
                            (({1'b0, r_iter} + (RW+1)'(1)) == {1'b0, r_count});
        // Window bounds are re-sampled at each wrap, so the new low applies immediately
        assign w_next_ptr = w_wrap ? w_low_cfg : r_ptr + AW'(C_ADDR_STEP);

        // A queue whose request is being accepted now may be granted again in the same
        // cycle using its post-accept pointer; this keeps one queue at full rate.
        assign w_elig[g]     = (r_state == S_RUN) && cfg_enable[g] && q_ready[g] &&
                               !w_held && !(w_acc && w_fin);
        assign w_addr_eff[g] = w_acc ? w_next_ptr : r_ptr;

        assign q_busy[g]    = (r_state == S_RUN);
        assign q_done[g]    = (r_state == S_DONE) && !r_cfg_err;
        assign q_cfg_err[g] = r_cfg_err;

        always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
            if (!axi_aresetn) begin
                r_state   <= S_IDLE;
                r_en_d    <= 1'b0;
                r_cfg_err <= 1'b0;
                r_ptr     <= '0;
                r_high    <= '0;
                r_iter    <= '0;
                r_count   <= '0;
            end else if (sw_rst) begin
                r_state   <= S_IDLE;
                r_en_d    <= 1'b0;
                r_cfg_err <= 1'b0;
                r_ptr     <= '0;
                r_high    <= '0;
                r_iter    <= '0;
                r_count   <= '0;
            end else begin
                r_en_d <= cfg_enable[g];
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_ptr   <= w_low_cfg;
                            r_high  <= w_high_cfg;
                            r_count <= w_count_cfg;
                            r_iter  <= '0;
                            if (w_high_cfg < w_low_cfg) begin
                                r_state   <= S_DONE;
                                r_cfg_err <= 1'b1;
                            end else begin
                                r_state <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        if (w_acc) begin
                            r_ptr <= w_next_ptr;
                            if (w_wrap) begin
                                r_iter  <= w_iter_inc;
                                r_high  <= w_high_cfg;
                                r_count <= w_count_cfg;
                            end
                        end
                        // Disable waits for an outstanding request to finish its handshake
                        if (!cfg_enable[g] && !w_held) begin
                            r_state <= S_IDLE;
                        end else if (w_acc && w_fin) begin
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (!cfg_enable[g]) begin
                            r_state   <= S_IDLE;
                            r_cfg_err <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end

`ifdef PCAP_REPLAY_SCHED_STATS_EN
        logic [31:0] r_stat;

        always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
            if (!axi_aresetn) begin
                r_stat <= '0;
            end else if (sw_rst || w_start) begin
                r_stat <= '0;
            end else if (w_acc) begin
                r_stat <= r_stat + 32'd1;
            end
        end

        assign stat_req_count[g*32 +: 32] = r_stat;
`endif
    end

    // First eligible queue at or after the round-robin pointer
    always_comb begin
        w_found    = 1'b0;
        w_gnt_qid  = '0;
        w_gnt_addr = '0;
        w_gnt_rr   = '0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!w_found && w_elig[i] && (((int'(r_rr) + k) % N) == i)) begin
                    w_found    = 1'b1;
                    w_gnt_qid  = QW'(i);
                    w_gnt_addr = w_addr_eff[i];
                    w_gnt_rr   = QW'((i + 1) % N);
                end
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_qid   <= '0;
            r_rr    <= '0;
        end else if (sw_rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_qid   <= '0;
            r_rr    <= '0;
        end else if (!r_valid || w_accept) begin
            r_valid <= w_found;
            if (w_found) begin
                r_addr <= w_gnt_addr;
                r_qid  <= w_gnt_qid;
                r_rr   <= w_gnt_rr;
            end
        end
    end

endmodule

// File: tb/tb_pcap_replay_multiq_sched.sv
// tb/tb_pcap_replay_multiq_sched.sv - scoreboard bench for the multi-queue replay scheduler
module tb_pcap_replay_multiq_sched;

    localparam int N  = 4;
    localparam int AW = 19;
    localparam int RW = 32;
    localparam int QW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            sw_rst;
    logic [N-1:0]    en;
    logic [N*AW-1:0] lo;
    logic [N*AW-1:0] hi;
    logic [N*RW-1:0] cnt;
    logic [N-1:0]    qr;
    logic            rdy;
    logic            rd_req_valid;
    logic [AW-1:0]   rd_req_addr;
    logic [QW-1:0]   rd_req_qid;
    logic [N-1:0]    q_busy;
    logic [N-1:0]    q_done;
    logic [N-1:0]    q_cfg_err;
`ifdef PCAP_REPLAY_SCHED_STATS_EN
    logic [N*32-1:0] stat_req_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [QW+AW-1:0] sb_q [$];

    always #5 clk = ~clk;

    pcap_replay_multiq_sched #(
        .C_NUM_QUEUES       (N),
        .QDR_ADDR_WIDTH     (AW),
        .REPLAY_COUNT_WIDTH (RW),
        .C_ADDR_STEP        (1),
        .C_QID_WIDTH        (QW)
    ) dut (
        .axi_aclk         (clk),
        .axi_aresetn      (rst_n),
        .sw_rst           (sw_rst),
        .cfg_enable       (en),
        .cfg_addr_low     (lo),
        .cfg_addr_high    (hi),
        .cfg_replay_count (cnt),
        .q_ready          (qr),
        .rd_req_valid     (rd_req_valid),
        .rd_req_ready     (rdy),
        .rd_req_addr      (rd_req_addr),
        .rd_req_qid       (rd_req_qid),
        .q_busy           (q_busy),
        .q_done           (q_done),
        .q_cfg_err        (q_cfg_err)
`ifdef PCAP_REPLAY_SCHED_STATS_EN
        ,
        .stat_req_count   (stat_req_count)
`endif
    );

    task automatic set_q(input int i, input logic [AW-1:0] l, input logic [AW-1:0] h,
                         input logic [RW-1:0] c);
        lo[i*AW +: AW]  = l;
        hi[i*AW +: AW]  = h;
        cnt[i*RW +: RW] = c;
    endtask

    task automatic push(input logic [QW-1:0] q, input logic [AW-1:0] a);
        sb_q.push_back({q, a});
    endtask

    // Checks the current negedge first, then one per negedge; returns on the last handshake
    task automatic collect(input int n, input int budget, output int span);
        int got;
        int cyc;
        int first;
        logic [QW+AW-1:0] exp_v;
        got = 0;
        cyc = 0;
        first = -1;
        while (1) begin
            if (rd_req_valid && rdy) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got qid=%0d addr=%h, required no request",
                             rd_req_qid, rd_req_addr);
                end else begin
                    exp_v = sb_q.pop_front();
                    if ({rd_req_qid, rd_req_addr} !== exp_v) begin
                        n_fail++;
                        $display("FAIL sb_req: got qid=%0d addr=%h, required qid=%0d addr=%h",
                                 rd_req_qid, rd_req_addr, exp_v[QW+AW-1:AW], exp_v[AW-1:0]);
                    end
                end
                if (first < 0) first = cyc;
                got++;
            end
            if (got >= n || cyc >= budget) break;
            @(negedge clk);
            cyc++;
        end
        if (got < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL collect_timeout: got %0d requests, required %0d", got, n);
        end
        span = (first < 0) ? 0 : (cyc - first + 1);
    endtask

    task automatic wait_valid(input int budget);
        int c;
        c = 0;
        while (!rd_req_valid && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (!rd_req_valid) begin
            n_fail++;
            $display("FAIL wait_valid: rd_req_valid=0 after %0d cycles, required 1", budget);
        end
    endtask

    task automatic go_idle();
        en  = '0;
        qr  = '1;
        rdy = 1'b1;
        repeat (3) @(negedge clk);
        sb_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rd_req_valid, rd_req_addr, rd_req_qid} !== '0) begin
            n_fail++;
            $display("FAIL reset_req: got v=%b addr=%h qid=%0d, required all 0",
                     rd_req_valid, rd_req_addr, rd_req_qid);
        end
        n_checks++;
        if ({q_busy, q_done, q_cfg_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_status: got busy=%b done=%b err=%b, required 0",
                     q_busy, q_done, q_cfg_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_queue();
        int span;
        set_q(0, 19'h10, 19'h13, 32'd2);
        qr = '1;
        rdy = 1'b1;
        for (int it = 0; it < 2; it++)
            for (int a = 'h10; a <= 'h13; a++) push(2'd0, AW'(a));
        en = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (rd_req_valid !== 1'b0 || q_busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL start_latency: got valid=%b busy0=%b, required valid=0 busy0=1",
                     rd_req_valid, q_busy[0]);
        end
        collect(8, 30, span);
        n_checks++;
        if (span !== 8) begin
            n_fail++;
            $display("FAIL single_span: got %0d cycles, required 8", span);
        end
        @(negedge clk);
        n_checks++;
        if (q_done[0] !== 1'b1 || q_busy[0] !== 1'b0 || rd_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got done0=%b busy0=%b valid=%b, required 1 0 0",
                     q_done[0], q_busy[0], rd_req_valid);
        end
        en = '0;
        @(negedge clk);
        n_checks++;
        if (q_done[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL done_clear: got done0=%b, required 0", q_done[0]);
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        int span;
        sw_rst = 1'b1;
        @(negedge clk);
        sw_rst = 1'b0;
        n_checks++;
        if (rd_req_valid !== 1'b0 || q_busy !== '0) begin
            n_fail++;
            $display("FAIL sw_rst: got valid=%b busy=%b, required 0", rd_req_valid, q_busy);
        end
        set_q(0, 19'h100, 19'h1FF, 32'd0);
        set_q(1, 19'h200, 19'h2FF, 32'd0);
        set_q(2, 19'h300, 19'h3FF, 32'd0);
        for (int r = 0; r < 2; r++)
            for (int q = 0; q < 3; q++) push(QW'(q), AW'(('h100 * (q + 1)) + r));
        en = 4'b0111;
        collect(6, 20, span);
        en = '0;
        n_checks++;
        if (span !== 6) begin
            n_fail++;
            $display("FAIL rr_span: got %0d cycles, required 6", span);
        end
        @(negedge clk);
        n_checks++;
        if (rd_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_stop: got valid=%b, required 0", rd_req_valid);
        end
        go_idle();
    endtask

    task automatic test_backpressure();
        int span;
        set_q(0, 19'h40, 19'h4F, 32'd0);
        rdy = 1'b0;
        en = 4'b0001;
        @(negedge clk);
        wait_valid(10);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (rd_req_valid !== 1'b1 || rd_req_qid !== 2'd0 || rd_req_addr !== 19'h40) begin
                n_fail++;
                $display("FAIL bp_hold: got v=%b qid=%0d addr=%h, required v=1 qid=0 addr=40",
                         rd_req_valid, rd_req_qid, rd_req_addr);
            end
            if (c == 1) qr[0] = 1'b0;
            @(negedge clk);
        end
        rdy = 1'b1;
        push(2'd0, 19'h40);
        collect(1, 4, span);
        @(negedge clk);
        n_checks++;
        if (rd_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_qready: got valid=%b with q_ready low, required 0", rd_req_valid);
        end
        qr[0] = 1'b1;
        push(2'd0, 19'h41);
        collect(1, 4, span);
        en = '0;
        @(negedge clk);
        n_checks++;
        if (rd_req_valid !== 1'b0 || q_busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stop: got valid=%b busy0=%b, required 0 0", rd_req_valid, q_busy[0]);
        end
        go_idle();
    endtask

    task automatic test_cfg_err();
        bit seen;
        set_q(1, 19'h20, 19'h1F, 32'd1);
        en = 4'b0010;
        @(negedge clk);
        n_checks++;
        if (q_cfg_err[1] !== 1'b1 || q_done[1] !== 1'b0 || q_busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_set: got err1=%b done1=%b busy1=%b, required 1 0 0",
                     q_cfg_err[1], q_done[1], q_busy[1]);
        end
        seen = 1'b0;
        repeat (5) begin
            if (rd_req_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_noreq: got request=%b, required 0", seen);
        end
        en = '0;
        @(negedge clk);
        n_checks++;
        if (q_cfg_err[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_clear: got err1=%b, required 0", q_cfg_err[1]);
        end
        go_idle();
    endtask

    task automatic test_disable_held();
        int span;
        bit seen;
        set_q(0, 19'h50, 19'h5F, 32'd0);
        rdy = 1'b0;
        en = 4'b0001;
        @(negedge clk);
        wait_valid(10);
        en[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rd_req_valid !== 1'b1 || rd_req_addr !== 19'h50 || q_busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL dis_hold: got v=%b addr=%h busy0=%b, required 1 50 1",
                     rd_req_valid, rd_req_addr, q_busy[0]);
        end
        rdy = 1'b1;
        push(2'd0, 19'h50);
        collect(1, 2, span);
        @(negedge clk);
        n_checks++;
        if (q_busy[0] !== 1'b0 || rd_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL dis_idle: got busy0=%b valid=%b, required 0 0", q_busy[0], rd_req_valid);
        end
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rd_req_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL dis_noreq: got request=%b, required 0", seen);
        end
        go_idle();
    endtask

    task automatic test_single_addr();
        int span;
        set_q(3, 19'h77, 19'h77, 32'd3);
        repeat (3) push(2'd3, 19'h77);
        en = 4'b1000;
        collect(3, 10, span);
        n_checks++;
        if (span !== 3) begin
            n_fail++;
            $display("FAIL one_addr_span: got %0d cycles, required 3", span);
        end
        @(negedge clk);
        n_checks++;
        if (q_done[3] !== 1'b1 || rd_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL one_addr_done: got done3=%b valid=%b, required 1 0", q_done[3], rd_req_valid);
        end
        go_idle();
    endtask

    task automatic test_areset_restart();
        int span;
        set_q(0, 19'h60, 19'h61, 32'd2);
        push(2'd0, 19'h60);
        push(2'd0, 19'h61);
        push(2'd0, 19'h60);
        en = 4'b0001;
        collect(3, 10, span);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rd_req_valid !== 1'b0 || q_busy !== '0) begin
            n_fail++;
            $display("FAIL areset: got valid=%b busy=%b, required 0", rd_req_valid, q_busy);
        end
`ifdef PCAP_REPLAY_SCHED_STATS_EN
        n_checks++;
        if (stat_req_count[31:0] !== 32'd0) begin
            n_fail++;
            $display("FAIL stat_reset: got %0d, required 0", stat_req_count[31:0]);
        end
`endif
        en = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            push(2'd0, 19'h60);
            push(2'd0, 19'h61);
        end
        en = 4'b0001;
        collect(4, 12, span);
        @(negedge clk);
        n_checks++;
        if (q_done[0] !== 1'b1 || rd_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_done: got done0=%b valid=%b, required 1 0", q_done[0], rd_req_valid);
        end
`ifdef PCAP_REPLAY_SCHED_STATS_EN
        n_checks++;
        if (stat_req_count[31:0] !== 32'd4) begin
            n_fail++;
            $display("FAIL stat_count: got %0d, required 4", stat_req_count[31:0]);
        end
`endif
        go_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        sw_rst = 1'b0;
        en     = '0;
        lo     = '0;
        hi     = '0;
        cnt    = '0;
        qr     = '1;
        rdy    = 1'b1;
        test_reset();
        test_single_queue();
        test_back_to_back();
        test_backpressure();
        test_cfg_err();
        test_disable_held();
        test_single_addr();
        test_areset_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
